// File: rtl/rdm_user_scheduler.sv
// Per-user combine scheduler: walks the configured users and hands each one to
// the RDM fetch FSM, with per-user watchdog, skip handling and an abort flush.
module rdm_user_scheduler #(
    parameter int USER_MAX = 16,
    parameter int TMO_W    = 16
) (
    input  logic                i_core_clk,
    input  logic                i_rx_rst,
    input  logic                i_cfg_we,
    input  logic [3:0]          i_cfg_addr,
    input  logic [13:0]         i_cfg_e01_size,
    input  logic [15:0]         i_cfg_ncb_size,
    input  logic                i_start,
    input  logic [4:0]          i_user_num,
    input  logic [TMO_W-1:0]    i_tmo_limit,
    input  logic                i_abort,
    input  logic                i_RDM_Data_Comp,
    output logic                o_Combine_process_request,
    output logic [3:0]          o_Combine_user_index,
    output logic [13:0]         o_Current_Combine_E01_Size,
    output logic [15:0]         o_Current_Combine_Ncb_Size,
    output logic                o_rx_fsm_rstn,
    output logic                o_busy,
    output logic                o_done,
    output logic [USER_MAX-1:0] o_user_skip,
    output logic [USER_MAX-1:0] o_user_tmo
);

    // state    | meaning
    // ST_IDLE  | waiting for a valid i_start
    // ST_LOAD  | copy config entry of the current user, skip if a size is 0
    // ST_REQ   | one-cycle request to the fetch FSM, watchdog cleared
    // ST_RUN   | waiting for completion, watchdog counting
    // ST_NEXT  | advance to next user or finish
    // ST_FLUSH | fetch FSM held in reset for two cycles
    // ST_DONE  | one-cycle pass-complete pulse
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_REQ, ST_RUN, ST_NEXT, ST_FLUSH, ST_DONE
    } state_t;

    localparam logic [4:0] USER_CNT_MAX = 5'(USER_MAX);

    state_t            state;
    logic [29:0]       cfg_tbl [USER_MAX];
    logic [3:0]        index;
    logic [4:0]        user_cnt;
    logic [TMO_W-1:0]  wd_cnt;
    logic              flush_cnt;
    logic              flush_to_idle;
    logic [29:0]       cur_entry;
    logic              start_ok;
    logic              wd_expired;
    logic              last_user;

    assign cur_entry  = cfg_tbl[index];
    assign start_ok   = i_start && (i_user_num != 5'd0) && (i_user_num <= USER_CNT_MAX);
    assign wd_expired = (i_tmo_limit != '0) && (wd_cnt == i_tmo_limit);
    assign last_user  = (({1'b0, index} + 5'd1) == user_cnt);

    assign o_Combine_user_index = index;

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            for (int i = 0; i < USER_MAX; i++) begin
                cfg_tbl[i] <= '0;
            end
        end else if (i_cfg_we) begin
            cfg_tbl[i_cfg_addr] <= {i_cfg_e01_size, i_cfg_ncb_size};
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state                      <= ST_IDLE;
            index                      <= '0;
            user_cnt                   <= '0;
            wd_cnt                     <= '0;
            flush_cnt                  <= 1'b0;
            flush_to_idle              <= 1'b0;
            o_Combine_process_request  <= 1'b0;
            o_Current_Combine_E01_Size <= '0;
            o_Current_Combine_Ncb_Size <= '0;
            o_rx_fsm_rstn              <= 1'b1;
            o_busy                     <= 1'b0;
            o_done                     <= 1'b0;
            o_user_skip                <= '0;
            o_user_tmo                 <= '0;
        end else begin
            o_Combine_process_request <= 1'b0;
            o_done                    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        user_cnt    <= i_user_num;
                        index       <= '0;
                        o_user_skip <= '0;
                        o_user_tmo  <= '0;
                        o_busy      <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (i_abort) begin
                        state         <= ST_FLUSH;
                        flush_cnt     <= 1'b0;
                        flush_to_idle <= 1'b1;
                        o_rx_fsm_rstn <= 1'b0;
                    end else begin
                        o_Current_Combine_E01_Size <= cur_entry[29:16];
                        o_Current_Combine_Ncb_Size <= cur_entry[15:0];
                        if (cur_entry[29:16] == '0 || cur_entry[15:0] == '0) begin
                            o_user_skip[index] <= 1'b1;
                            state              <= ST_NEXT;
                        end else begin
                            o_Combine_process_request <= 1'b1;
                            state                     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    wd_cnt <= '0;
                    if (i_abort) begin
                        state         <= ST_FLUSH;
                        flush_cnt     <= 1'b0;
                        flush_to_idle <= 1'b1;
                        o_rx_fsm_rstn <= 1'b0;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    wd_cnt <= (&wd_cnt) ? wd_cnt : wd_cnt + 1'b1;
                    // abort beats completion, completion beats timeout
                    if (i_abort) begin
                        state         <= ST_FLUSH;
                        flush_cnt     <= 1'b0;
                        flush_to_idle <= 1'b1;
                        o_rx_fsm_rstn <= 1'b0;
                    end else if (i_RDM_Data_Comp) begin
                        state <= ST_NEXT;
                    end else if (wd_expired) begin
                        o_user_tmo[index] <= 1'b1;
                        state             <= ST_FLUSH;
                        flush_cnt         <= 1'b0;
                        flush_to_idle     <= 1'b0;
                        o_rx_fsm_rstn     <= 1'b0;
                    end
                end
                ST_NEXT: begin
                    if (i_abort) begin
                        state         <= ST_FLUSH;
                        flush_cnt     <= 1'b0;
                        flush_to_idle <= 1'b1;
                        o_rx_fsm_rstn <= 1'b0;
                    end else if (last_user) begin
                        o_done <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        index <= index + 4'd1;
                        state <= ST_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt) begin
                        o_rx_fsm_rstn <= 1'b1;
                        if (flush_to_idle) begin
                            o_busy <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_NEXT;
                        end
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
